// File: rtl/aes_usb_pkg.sv
// Shared types and sizes for the AES-to-USB datapath.
package aes_usb_pkg;
  localparam int BLOCK_W   = 128;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 16;

  typedef enum logic {IDLE, SEND} ser_state_t;
  typedef logic [BLOCK_W-1:0] block_t;
endpackage

// File: rtl/block_slot_buf.sv
// Two-entry block buffer. Writes land at wr_ptr; the block at rd_ptr is the one
// being serialized and is released by rd_free.
module block_slot_buf
  import aes_usb_pkg::*;
#(
  parameter int W = BLOCK_W
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_free,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] slots [2];
  logic         wr_ptr;
  logic         rd_ptr;

  assign rd_data = slots[rd_ptr];

  // With both slots full wr_ptr == rd_ptr, so a write coinciding with rd_free
  // refills the slot being released; the reader still sees the old block.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      slots[0] <= '0;
      slots[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (wr_en) begin
        slots[wr_ptr] <= wr_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (rd_free) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(wr_en) - 2'(rd_free);
    end
  end

endmodule

// File: rtl/block_serializer.sv
// Splits buffered 128-bit blocks into bytes and pushes them into the outbound
// byte FIFO, one byte per cycle unless the FIFO is full.
module block_serializer #(
  parameter int NUM_BYTES = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   blk_valid,
  input  logic [8*NUM_BYTES-1:0] blk_data,
  input  logic                   fifo_full,
  input  logic                   clr_err,
  output logic                   push,
  output logic [7:0]             byte_out,
  output logic                   busy,
  output logic                   blk_done,
  output logic                   overflow
);
  import aes_usb_pkg::*;

  localparam int                 BW       = BYTE_W * NUM_BYTES;
  localparam int                 IDX_W    = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_BYTES - 1);

  ser_state_t       state;
  logic [IDX_W-1:0] byte_idx;
  logic [IDX_W-1:0] eff_idx;
  logic [BW-1:0]    rd_data;
  logic [1:0]       count;
  logic             last_push;
  logic             accept;
  logic             drop;

  // Handshake: a byte transfers on every rising edge where push is high; push
  // already accounts for fifo_full, so the FIFO needs no further qualification.
  assign push      = (state == SEND) && !fifo_full;
  assign last_push = push && (byte_idx == LAST_IDX);
  assign accept    = blk_valid && ((count != 2'd2) || last_push);
  assign drop      = blk_valid && !accept;
  assign busy      = (count != 2'd0);

  assign eff_idx  = MSB_FIRST ? (LAST_IDX - byte_idx) : byte_idx;
  assign byte_out = push ? rd_data[eff_idx*BYTE_W +: BYTE_W] : 8'h00;

  block_slot_buf #(.W(BW)) u_slots (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (accept),
    .wr_data (blk_data),
    .rd_free (last_push),
    .rd_data (rd_data),
    .count   (count)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      byte_idx <= '0;
      blk_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      blk_done <= last_push;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (push) begin
            if (byte_idx == LAST_IDX) begin
              byte_idx <= '0;
              // Stay in SEND when the other slot still holds (or just received) a block.
              if ((count == 2'd1) && !accept) begin
                state <= IDLE;
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
